// File: rtl/stream_player_pkg.sv
// Shared constants and types for the stream_player sample playback block.
package stream_player_pkg;

    localparam logic [1:0] CsrCtrl   = 2'd0;
    localparam logic [1:0] CsrStatus = 2'd1;
    localparam logic [1:0] CsrLength = 2'd2;
    localparam logic [1:0] CsrLoops  = 2'd3;

    localparam int unsigned CtrlStart = 0;
    localparam int unsigned CtrlStop  = 1;
    localparam int unsigned CtrlLoop  = 2;

    localparam int unsigned StatBusy = 0;
    localparam int unsigned StatDone = 1;
    localparam int unsigned StatIrq  = 2;

    localparam logic [15:0] LoopsMax = 16'hFFFF;

    typedef enum logic [1:0] {
        StIdle,
        StPlay,
        StDrain
    } state_e;

endpackage

// File: rtl/player_ram.sv
// Per-channel sample store: one write port, one synchronous read port with enable.
module player_ram #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic                  re_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [WIDTH-1:0]      rdata_o
);

    logic [WIDTH-1:0] mem_q [2**DEPTH_LOG2];
    logic [WIDTH-1:0] rdata_q, rdata_d;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register doubles as the output stage, so it holds while re_i is low.
    always_comb begin
        rdata_d = rdata_q;
        if (re_i) begin
            rdata_d = mem_q[raddr_i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/stream_player.sv
// Multi-channel sample player: CSR bank, playback FSM and per-channel sample RAMs.
module stream_player
    import stream_player_pkg::*;
#(
    parameter int unsigned CHANNELS   = 1,
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH_LOG2 = 10,
    localparam int unsigned CH_LOG2   = (CHANNELS > 1) ? $clog2(CHANNELS) : 0,
    localparam int unsigned AW        = DEPTH_LOG2 + CH_LOG2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      buffer_write,
    input  logic [AW-1:0]             buffer_address,
    input  logic [31:0]               buffer_writedata,
    input  logic [1:0]                csr_address,
    input  logic                      csr_write,
    input  logic                      csr_read,
    input  logic [31:0]               csr_writedata,
    output logic [31:0]               csr_readdata,
    output logic                      irq,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int unsigned ChW  = (CH_LOG2 > 0) ? CH_LOG2 : 1;
    localparam int unsigned LenW = DEPTH_LOG2 + 1;
    localparam logic [LenW-1:0] DepthLen = LenW'(2**DEPTH_LOG2);

    state_e                state_q, state_d;
    logic [DEPTH_LOG2-1:0] rd_addr_q, rd_addr_d;
    logic [15:0]           loops_q, loops_d;
    logic [LenW-1:0]       length_q, length_d;
    logic                  loop_q, loop_d;
    logic                  done_q, done_d;
    logic                  irq_q, irq_d;
    logic                  out_valid_q, out_valid_d;
    logic [31:0]           csr_readdata_q, csr_readdata_d;

    logic                  start, stop, advance, last, rd_en;
    logic [LenW-1:0]       len_eff;
    logic [ChW-1:0]        wr_chan;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic [31:0]           rdata;
    logic                  unused_bits;

    assign unused_bits = ^{buffer_writedata, csr_writedata};

    if (CH_LOG2 == 0) begin : g_one_ch
        assign wr_chan = '0;
        assign wr_idx  = buffer_address;
    end else begin : g_multi_ch
        assign wr_chan = buffer_address[CH_LOG2-1:0];
        assign wr_idx  = buffer_address[AW-1:CH_LOG2];
    end

    // Channel indices at or above CHANNELS match no instance and are dropped.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        player_ram #(
            .WIDTH      (WIDTH),
            .DEPTH_LOG2 (DEPTH_LOG2)
        ) u_ram (
            .clk_i   (clk),
            .rst_i   (reset),
            .we_i    (buffer_write && (wr_chan == ChW'(i))),
            .waddr_i (wr_idx),
            .wdata_i (buffer_writedata[WIDTH-1:0]),
            .re_i    (rd_en),
            .raddr_i (rd_addr_q),
            .rdata_o (out_data[i*WIDTH +: WIDTH])
        );
    end

    assign start   = csr_write && (csr_address == CsrCtrl) && csr_writedata[CtrlStart];
    assign stop    = csr_write && (csr_address == CsrCtrl) && csr_writedata[CtrlStop];
    assign advance = !out_valid_q || out_ready;
    assign len_eff = ((length_q == '0) || (length_q > DepthLen)) ? DepthLen : length_q;
    assign last    = ({1'b0, rd_addr_q} == (len_eff - LenW'(1)));

    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        loops_d     = loops_q;
        length_d    = length_q;
        loop_d      = loop_q;
        done_d      = done_q;
        irq_d       = irq_q;
        out_valid_d = out_valid_q;
        rd_en       = 1'b0;

        if (csr_write && (csr_address == CsrCtrl)) begin
            loop_d = csr_writedata[CtrlLoop];
        end
        if (csr_write && (csr_address == CsrLength)) begin
            length_d = csr_writedata[DEPTH_LOG2:0];
        end
        // Clear first so a completion in the same cycle overrides it.
        if (csr_write && (csr_address == CsrStatus) && csr_writedata[StatIrq]) begin
            irq_d = 1'b0;
        end

        if (start) begin
            state_d     = StPlay;
            rd_addr_d   = '0;
            loops_d     = '0;
            done_d      = 1'b0;
            out_valid_d = 1'b0;
        end else if (stop && (state_q != StIdle)) begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                StPlay: begin
                    if (advance) begin
                        rd_en       = 1'b1;
                        out_valid_d = 1'b1;
                        if (!last) begin
                            rd_addr_d = rd_addr_q + DEPTH_LOG2'(1);
                        end else if (loop_q) begin
                            rd_addr_d = '0;
                            if (loops_q != LoopsMax) begin
                                loops_d = loops_q + 16'd1;
                            end
                        end else begin
                            state_d = StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        done_d      = 1'b1;
                        irq_d       = 1'b1;
                        state_d     = StIdle;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        case (csr_address)
            CsrCtrl:   rdata[CtrlLoop] = loop_q;
            CsrStatus: begin
                rdata[StatBusy] = (state_q != StIdle);
                rdata[StatDone] = done_q;
                rdata[StatIrq]  = irq_q;
            end
            CsrLength: rdata[DEPTH_LOG2:0] = length_q;
            default:   rdata[15:0] = loops_q;
        endcase
        csr_readdata_d = csr_read ? rdata : csr_readdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            rd_addr_q      <= '0;
            loops_q        <= '0;
            length_q       <= '0;
            loop_q         <= 1'b0;
            done_q         <= 1'b0;
            irq_q          <= 1'b0;
            out_valid_q    <= 1'b0;
            csr_readdata_q <= '0;
        end else begin
            state_q        <= state_d;
            rd_addr_q      <= rd_addr_d;
            loops_q        <= loops_d;
            length_q       <= length_d;
            loop_q         <= loop_d;
            done_q         <= done_d;
            irq_q          <= irq_d;
            out_valid_q    <= out_valid_d;
            csr_readdata_q <= csr_readdata_d;
        end
    end

    assign csr_readdata = csr_readdata_q;
    assign irq          = irq_q;
    assign out_valid    = out_valid_q;

endmodule

// File: tb/tb_stream_player.sv
// Directed self-checking bench for stream_player with two 8-bit channels of depth 8.
module tb_stream_player;

    localparam int unsigned CHANNELS   = 2;
    localparam int unsigned WIDTH      = 8;
    localparam int unsigned DEPTH_LOG2 = 3;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_LENGTH = 2'd2;
    localparam logic [1:0] A_LOOPS  = 2'd3;

    logic        clk = 1'b0;
    logic        reset;
    logic        buffer_write;
    logic [3:0]  buffer_address;
    logic [31:0] buffer_writedata;
    logic [1:0]  csr_address;
    logic        csr_write;
    logic        csr_read;
    logic [31:0] csr_writedata;
    logic [31:0] csr_readdata;
    logic        irq;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_player #(
        .CHANNELS   (CHANNELS),
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .buffer_write     (buffer_write),
        .buffer_address   (buffer_address),
        .buffer_writedata (buffer_writedata),
        .csr_address      (csr_address),
        .csr_write        (csr_write),
        .csr_read         (csr_read),
        .csr_writedata    (csr_writedata),
        .csr_readdata     (csr_readdata),
        .irq              (irq),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready)
    );

    function automatic logic [15:0] exp_beat(input int i);
        logic [7:0] c0, c1;
        c0 = 8'(32'h10 + i);
        c1 = 8'(32'h20 + i);
        return {c1, c0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
        csr_address   = a;
        csr_writedata = d;
        csr_write     = 1'b1;
        tick();
        csr_write     = 1'b0;
    endtask

    task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
        csr_address = a;
        csr_read    = 1'b1;
        tick();
        csr_read    = 1'b0;
        d           = csr_readdata;
    endtask

    task automatic buf_wr(input int idx, input int ch, input logic [31:0] d);
        buffer_address   = 4'(idx * 2 + ch);
        buffer_writedata = d;
        buffer_write     = 1'b1;
        tick();
        buffer_write     = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || irq !== 1'b0 || out_data !== 16'h0 || csr_readdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b irq=%b data=%h rd=%h, expected all zero",
                     out_valid, irq, out_data, csr_readdata);
        end
        csr_rd(A_STATUS, r);
        checks++;
        if (r !== 32'h0) begin
            errors++;
            $display("FAIL reset_status: got %h, expected 0", r);
        end
        csr_rd(A_LENGTH, r);
        checks++;
        if (r !== 32'h0) begin
            errors++;
            $display("FAIL reset_length: got %h, expected 0", r);
        end
        csr_rd(A_CTRL, r);
        checks++;
        if (r !== 32'h0) begin
            errors++;
            $display("FAIL reset_ctrl: got %h, expected 0", r);
        end
    endtask

    task automatic load_buffers();
        for (int i = 0; i < 8; i++) begin
            buf_wr(i, 0, 32'h10 + i);
            buf_wr(i, 1, 32'h20 + i);
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] r;
        out_ready = 1'b1;
        csr_wr(A_LENGTH, 32'd4);
        csr_wr(A_CTRL, 32'h1);
        csr_address = A_STATUS;
        csr_read    = 1'b1;
        tick();
        csr_read    = 1'b0;
        checks++;
        if (csr_readdata !== 32'h1) begin
            errors++;
            $display("FAIL oneshot_busy: got %h, expected 1", csr_readdata);
        end
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_beat(k)) begin
                errors++;
                $display("FAIL oneshot_beat%0d: got valid=%b data=%h, expected valid=1 data=%h",
                         k, out_valid, out_data, exp_beat(k));
            end
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || irq !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_done: got valid=%b irq=%b, expected valid=0 irq=1",
                     out_valid, irq);
        end
        csr_rd(A_STATUS, r);
        checks++;
        if (r !== 32'h6) begin
            errors++;
            $display("FAIL oneshot_status: got %h, expected 6", r);
        end
        csr_wr(A_STATUS, 32'h4);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_irq_clear: got irq=%b, expected 0", irq);
        end
    endtask

    task automatic test_stall();
        int         beat;
        logic [15:0] held;
        logic        stalled;
        beat = 0;
        csr_wr(A_CTRL, 32'h1);
        for (int c = 0; c < 40 && beat < 4; c++) begin
            out_ready = (c % 3 == 0);
            if (out_valid && out_ready) begin
                checks++;
                if (out_data !== exp_beat(beat)) begin
                    errors++;
                    $display("FAIL stall_beat%0d: got data=%h, expected %h",
                             beat, out_data, exp_beat(beat));
                end
                beat++;
            end
            stalled = out_valid && !out_ready;
            held    = out_data;
            tick();
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== held) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%b data=%h, expected valid=1 data=%h",
                             out_valid, out_data, held);
                end
            end
        end
        checks++;
        if (beat != 4) begin
            errors++;
            $display("FAIL stall_count: got %0d beats, expected 4", beat);
        end
        checks++;
        if (out_valid !== 1'b0 || irq !== 1'b1) begin
            errors++;
            $display("FAIL stall_done: got valid=%b irq=%b, expected valid=0 irq=1",
                     out_valid, irq);
        end
        out_ready = 1'b1;
        csr_wr(A_STATUS, 32'h4);
    endtask

    task automatic test_loop();
        logic [31:0] r;
        out_ready = 1'b1;
        csr_wr(A_LENGTH, 32'd3);
        csr_wr(A_CTRL, 32'h5);
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_beat(k % 3)) begin
                errors++;
                $display("FAIL loop_beat%0d: got valid=%b data=%h, expected valid=1 data=%h",
                         k, out_valid, out_data, exp_beat(k % 3));
            end
        end
        csr_rd(A_LOOPS, r);
        checks++;
        if (r !== 32'd3) begin
            errors++;
            $display("FAIL loop_count: got %0d, expected 3", r);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL loop_irq: got irq=%b, expected 0", irq);
        end
        csr_wr(A_CTRL, 32'h2);
        checks++;
        if (out_valid !== 1'b0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL loop_stop: got valid=%b irq=%b, expected 0 0", out_valid, irq);
        end
    endtask

    task automatic test_stop();
        logic [31:0] r;
        out_ready = 1'b1;
        csr_wr(A_LENGTH, 32'd4);
        csr_wr(A_CTRL, 32'h1);
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_beat(1)) begin
            errors++;
            $display("FAIL stop_beat1: got valid=%b data=%h, expected valid=1 data=%h",
                     out_valid, out_data, exp_beat(1));
        end
        csr_wr(A_CTRL, 32'h2);
        checks++;
        if (out_valid !== 1'b0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL stop_abort: got valid=%b irq=%b, expected 0 0", out_valid, irq);
        end
        csr_rd(A_STATUS, r);
        checks++;
        if (r !== 32'h0) begin
            errors++;
            $display("FAIL stop_status: got %h, expected 0", r);
        end
    endtask

    task automatic test_len0_restart();
        logic [31:0] r;
        out_ready = 1'b1;
        csr_wr(A_LENGTH, 32'd0);
        csr_wr(A_CTRL, 32'h1);
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_beat(k)) begin
                errors++;
                $display("FAIL len0_beat%0d: got valid=%b data=%h, expected valid=1 data=%h",
                         k, out_valid, out_data, exp_beat(k));
            end
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || irq !== 1'b1) begin
            errors++;
            $display("FAIL len0_done: got valid=%b irq=%b, expected valid=0 irq=1",
                     out_valid, irq);
        end
        csr_wr(A_STATUS, 32'h4);
        csr_wr(A_CTRL, 32'h1);
        for (int k = 0; k < 8; k++) tick();
        out_ready = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_beat(7)) begin
            errors++;
            $display("FAIL drain_hold: got valid=%b data=%h, expected valid=1 data=%h",
                     out_valid, out_data, exp_beat(7));
        end
        csr_wr(A_CTRL, 32'h3);
        checks++;
        if (out_valid !== 1'b0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL restart_gap: got valid=%b irq=%b, expected 0 0", out_valid, irq);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_beat(0) || irq !== 1'b0) begin
            errors++;
            $display("FAIL restart_first: got valid=%b data=%h irq=%b, expected 1 %h 0",
                     out_valid, out_data, irq, exp_beat(0));
        end
        csr_rd(A_STATUS, r);
        checks++;
        if (r !== 32'h1) begin
            errors++;
            $display("FAIL restart_status: got %h, expected 1", r);
        end
        csr_wr(A_CTRL, 32'h2);
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        out_ready = 1'b1;
        csr_wr(A_LENGTH, 32'd4);
        csr_wr(A_CTRL, 32'h5);
        tick();
        csr_rd(A_STATUS, r);
        checks++;
        if (r !== 32'h1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy: got status=%h valid=%b, expected 1 1", r, out_valid);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || irq !== 1'b0 || out_data !== 16'h0 || csr_readdata !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset: got valid=%b irq=%b data=%h rd=%h, expected all zero",
                     out_valid, irq, out_data, csr_readdata);
        end
        csr_rd(A_CTRL, r);
        checks++;
        if (r !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_ctrl: got %h, expected 0", r);
        end
    endtask

    initial begin
        reset            = 1'b1;
        buffer_write     = 1'b0;
        buffer_address   = '0;
        buffer_writedata = '0;
        csr_address      = '0;
        csr_write        = 1'b0;
        csr_read         = 1'b0;
        csr_writedata    = '0;
        out_ready        = 1'b1;
        test_reset();
        load_buffers();
        test_oneshot();
        test_stall();
        test_loop();
        test_stop();
        test_len0_restart();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
